// File: rtl/shared_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter_if
// Purpose : bundles the request/data/grant signals shared between the bus
//           masters and the round-robin arbiter.
// Signals : req      - one request bit per master
//           data_in  - master i word at [i*WIDTH +: WIDTH]
//           grant    - registered one-hot grant (zero when no owner)
//           owner    - index of current owner, valid while bus_busy
//           bus_busy - high while a master owns the bus
//           timeout  - one-cycle pulse when an owner is preempted
// Modports: master - the requesting units (drive req/data_in)
//           slave  - the arbiter (drives grant/owner/bus_busy/timeout)
// ---------------------------------------------------------------------------
interface shared_bus_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       grant;
  logic [OW-1:0]      owner;
  logic               bus_busy;
  logic               timeout;

  modport master (output req, data_in, input grant, owner, bus_busy, timeout);
  modport slave  (input req, data_in, output grant, owner, bus_busy, timeout);
endinterface

// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter
// Purpose : N-master shared tri-state bus with round-robin arbitration, a
//           one-cycle turnaround between owners and a hold-time limit that
//           preempts an owner after MAX_HOLD cycles when others are waiting.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - arbiter side (slave modport) of shared_bus_arbiter_if
//           bus_o - WIDTH-bit tri-state bus, owner's word while busy else z
// bus_o is a plain net port so the high-impedance driver resolves on an
// ordinary wire at the instance boundary.
// ---------------------------------------------------------------------------
module shared_bus_arbiter #(
  parameter int WIDTH    = 4,
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shared_bus_arbiter_if.slave  bus,
  output wire  [WIDTH-1:0]     bus_o
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [OW-1:0] LAST_RST = OW'(N - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_grant;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_last_owner;
  logic [HW-1:0] r_hold_cnt;
  logic          r_busy;
  logic          r_timeout;

  // Round-robin: requesters above last_owner are preferred; if none, wrap
  // to the lowest-index requester overall.
  logic [N-1:0]  w_above_mask;
  logic [N-1:0]  w_req_above;
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_win_onehot;
  logic [OW-1:0] w_winner;
  logic          w_any_req;
  logic          w_owner_req;
  logic          w_others_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign w_above_mask[gi] = (OW'(gi) > r_last_owner);
  end

  assign w_req_above  = bus.req & w_above_mask;
  assign w_cand       = (|w_req_above) ? w_req_above : bus.req;
  // Isolate the lowest set bit of the candidate vector.
  assign w_win_onehot = w_cand & ~(w_cand - N'(1));
  assign w_any_req    = |bus.req;
  assign w_owner_req  = |(bus.req & r_grant);
  assign w_others_req = |(bus.req & ~r_grant);

  always_comb begin
    w_winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = OW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= LAST_RST;
      r_hold_cnt   <= '0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_TURN: begin
          if (w_any_req) begin
            r_state    <= S_OWN;
            r_grant    <= w_win_onehot;
            r_owner    <= w_winner;
            r_busy     <= 1'b1;
            r_hold_cnt <= HW'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OWN: begin
          // A release takes precedence over preemption on the same edge,
          // so the timeout pulse only fires while the owner still wants it.
          if (!w_owner_req || (r_hold_cnt == HOLD_MAX && w_others_req)) begin
            r_state      <= S_TURN;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
            r_hold_cnt   <= '0;
            r_timeout    <= w_owner_req;
          end else if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Each master's word is masked by its own grant bit, then OR-combined;
  // the one-hot grant guarantees at most one slice survives.
  logic [WIDTH-1:0] w_masked [N];
  logic [WIDTH-1:0] w_bus_data;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_masked[gi] = bus.data_in[gi*WIDTH +: WIDTH] & {WIDTH{r_grant[gi]}};
  end

  always_comb begin
    w_bus_data = '0;
    for (int i = 0; i < N; i++) begin
      w_bus_data = w_bus_data | w_masked[i];
    end
  end

  assign bus_o        = (|r_grant) ? w_bus_data : {WIDTH{1'bz}};
  assign bus.grant    = r_grant;
  assign bus.owner    = r_owner;
  assign bus.bus_busy = r_busy;
  assign bus.timeout  = r_timeout;
endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

Parametrised multi-master shared bus: N masters each present a WIDTH-bit word and a request, a round-robin arbiter grants the bus to one master, and only the granted master's word is driven onto a tri-state output. When the bus is idle or changing owner, the output is high-impedance. It generalises the single-source, enable-gated unidirectional bus to N sources, with arbitration, a turnaround cycle and a hold-time limit. It sits between the datapath units and any shared result or interconnect bus.

## Interface
- WIDTH, 4, data width of each master and of the bus
- N, 4, number of masters (2..16)
- MAX_HOLD, 16, cycles an owner may hold the bus before preemption when others are waiting (>=1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  request per master; bit i belongs to master i
- data_in  input  N*WIDTH  master i word at [i*WIDTH +: WIDTH]
- grant  output  N  registered one-hot grant, all-zero when no owner
- owner  output  max(1,clog2(N))  index of current owner, valid while bus_busy
- bus_busy  output  1  high while a master owns the bus
- timeout  output  1  one-cycle pulse when an owner is preempted
- bus_o  output  WIDTH  tri-state bus: data_in slice of owner while bus_busy, else all z

## Operation
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- States:
  - IDLE: no owner.
  - OWN: one master granted.
  - TURN: one-cycle turnaround with the bus at z.
- IDLE: if any req bit is high at an edge, the arbiter picks a winner and the block enters OWN. Otherwise it stays in IDLE.
- Winner selection:
  - Search starts at (last_owner+1) mod N and wraps, taking the first req bit found high.
  - last_owner resets to N-1, so master 0 has top priority after reset.
- OWN:
  - grant[owner]=1 and bus_busy=1.
  - bus_o equals the owner's data_in slice. This path is combinational from data_in and gated by the registered grant.
- Release: the owner's req is low at an edge -> enter TURN. last_owner becomes owner.
- Hold counter:
  - hold_cnt=1 in the first OWN cycle and increments each OWN cycle, saturating at MAX_HOLD.
  - If hold_cnt==MAX_HOLD and any other req bit is high at an edge -> enter TURN and pulse timeout for that TURN cycle.
  - If no other master is requesting, the owner keeps the bus indefinitely.
- Release and timeout at the same edge: treated as a normal release, with no timeout pulse.
- TURN:
  - grant=0, bus_busy=0, bus_o=z.
  - At the next edge, arbitrate exactly as in IDLE: go to OWN if any req is high, otherwise go to IDLE.
  - A preempted owner that is still requesting competes normally. Round-robin puts it last.
- The bus is never driven by two masters. The grant is one-hot or zero at all times.
- req bits may change on any cycle. Only values sampled at rising edges matter.

## Timing
- Reset (rst_n low, asynchronous, immediate):
  - state=IDLE, grant=0, owner=0, bus_busy=0, timeout=0, bus_o=z.
  - hold_cnt=0, last_owner=N-1.
- Reset mid-ownership: outputs return to their reset values immediately, without waiting for an edge. The first grant after reset goes to the lowest-index requester.
- Grant latency: req is sampled high at edge k in IDLE or TURN -> grant is visible after edge k.
- Release latency: req is sampled low at edge k -> grant drops after edge k. Next possible grant is after edge k+1, giving exactly one z cycle between owners.
- Preemption: the owner's MAX_HOLD-th OWN cycle ends at edge k with another req high -> TURN after edge k with timeout=1 for one cycle. The new owner is granted after edge k+1.
- owner and bus_busy change on the same edge as grant.

## Test plan
- Reset and idle: hold rst_n low, then release with req=0 for 10 cycles -> grant=0, bus_busy=0, bus_o=zzzz, timeout=0 throughout.
- Single master:
  - Stimulus: req=0100 at edge 1 with data_in[11:8]=4'hA; drop req at edge 5.
  - Response: grant=0100, owner=2 and bus_o=A after edge 1; grant=0 and bus_o=z after edge 5.
- Round-robin:
  - Stimulus: req=1111 held. Each owner drops its req for one edge after owning for 2 cycles, then re-raises it.
  - Response: owners follow 0,1,2,3,0. Exactly one z cycle between owners.
- Preemption:
  - Stimulus: MAX_HOLD=4; master 1 holds req while master 3 requests from cycle 2.
  - Response: master 1 owns for exactly 4 cycles, timeout pulses once, and master 3 is granted on the next edge.
- No preemption when alone: MAX_HOLD=4, master 0 holds req for 20 cycles -> grant stays 0001, timeout stays 0.
- Async reset mid-transfer: assert rst_n low between edges while master 2 owns -> bus_o=z and grant=0 before the next edge. After release with req=1100, master 2 wins.
